uart_receiver: RTL and testbench

//  Serial receive stage of the UART IP. Mirrors the transmitter.
//  - Oversamples the rx line at 16x baud.
//  - Detects and validates the start bit, then samples each bit at mid-bit.
//  - Checks parity and the stop bit.
//  - Writes each received word, with its error flags, into the rx FIFO.
//  - Sits between the rx conduit pin and the rx FIFO.
//  - Frame format and control fields match the transmitter (same control register).

---
 rtl/uart_receiver_if.sv | 22 ++
 rtl/uart_receiver.sv | 154 +++++++++++++++
 tb/tb_uart_receiver.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// FIFO-side bundle of the UART receive stage.
// Carries rx_full in and rx_write/rx_data/rx_overrun out.
interface uart_receiver_if;
  logic       rx_full;
  logic       rx_write;
  logic [9:0] rx_data;
  logic       rx_overrun;

  modport master (
    input  rx_full,
    output rx_write,
    output rx_data,
    output rx_overrun
  );

  modport slave (
    output rx_full,
    input  rx_write,
    input  rx_data,
    input  rx_overrun
  );
endinterface

// File: rtl/uart_receiver.sv
// UART serial receive stage: 16x oversampled rx line to rx FIFO.
// Ports: clk, reset, rx_clk_enable, rx_in, parityMode, wordSize, rx_busy, fifo.
module uart_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_clk_enable,
  input  logic       rx_in,
  input  logic [1:0] parityMode,
  input  logic       wordSize,
  output logic       rx_busy,
  uart_receiver_if.master fifo
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [CW-1:0]          cnt;
  logic [2:0]             bidx;
  logic [2:0]             last_idx;
  logic [7:0]             data_q;
  logic                   perr_q;
  logic [1:0]             pm_q;
  logic                   ws_q;
  logic                   par_exp;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  assign last_idx = ws_q ? 3'd7 : 3'd6;

  always_comb begin
    par_exp = 1'b1;
    unique case (pm_q)
      2'b01:   par_exp = ^data_q;
      2'b10:   par_exp = ~^data_q;
      default: par_exp = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      bidx            <= '0;
      data_q          <= '0;
      perr_q          <= 1'b0;
      pm_q            <= 2'b00;
      ws_q            <= 1'b0;
      fifo.rx_write   <= 1'b0;
      fifo.rx_overrun <= 1'b0;
      fifo.rx_data    <= '0;
    end else begin
      fifo.rx_write   <= 1'b0;
      fifo.rx_overrun <= 1'b0;
      if (rx_clk_enable) begin
        unique case (state)
          IDLE: begin
            if (!rxs) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            if (cnt == MID) begin
              if (rxs) begin
                state <= IDLE;
              end else begin
                // Frame format is frozen here for the whole frame.
                state  <= DATA;
                pm_q   <= parityMode;
                ws_q   <= wordSize;
                data_q <= '0;
                perr_q <= 1'b0;
                bidx   <= '0;
              end
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == LAST) begin
              cnt          <= '0;
              data_q[bidx] <= rxs;
              bidx         <= bidx + 1'b1;
              if (bidx == last_idx) begin
                state <= (pm_q != 2'b00) ? PARITY : STOP;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PARITY: begin
            if (cnt == LAST) begin
              cnt    <= '0;
              perr_q <= (rxs != par_exp);
              state  <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= rxs ? IDLE : BRK;
              // rx_full is judged in the stop-sample cycle.
              if (fifo.rx_full) begin
                fifo.rx_overrun <= 1'b1;
              end else begin
                fifo.rx_write <= 1'b1;
                fifo.rx_data  <= {~rxs, perr_q, data_q};
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          BRK: begin
            if (rxs) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver.
// Directed frames plus randomized frames vs a frame-level model.
module tb_uart_receiver;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [1:0] parityMode;
  logic       wordSize;
  logic       rx_busy;
  logic       en = 1'b0;
  logic [1:0] tcnt = 2'd0;

  uart_receiver_if bus ();

  uart_receiver dut (
    .clk           (clk),
    .reset         (reset),
    .rx_clk_enable (en),
    .rx_in         (rx_in),
    .parityMode    (parityMode),
    .wordSize      (wordSize),
    .rx_busy       (rx_busy),
    .fifo          (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tcnt <= tcnt + 2'd1;
    en   <= (tcnt == 2'd2);
  end

  logic [9:0] wq[$];
  int         ov_cnt = 0;
  int         nvec = 0;
  int         nerr = 0;

  always @(negedge clk) begin
    if (bus.rx_write === 1'b1) wq.push_back(bus.rx_data);
    if (bus.rx_overrun === 1'b1) ov_cnt = ov_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] model(input logic [7:0] d,
                                       input logic ws,
                                       input logic [1:0] pm,
                                       input logic pbit,
                                       input logic stop);
    logic [7:0] dd;
    logic       e;
    logic       perr;
    dd   = ws ? d : (d & 8'h7F);
    e    = 1'b1;
    if (pm == 2'd1) e = ($countones(dd) % 2) == 1;
    if (pm == 2'd2) e = ($countones(dd) % 2) == 0;
    perr = (pm != 2'd0) && (pbit != e);
    return {~stop, perr, dd};
  endfunction

  function automatic logic good_par(input logic [7:0] d,
                                    input logic ws,
                                    input logic [1:0] pm);
    logic [7:0] dd;
    dd = ws ? d : (d & 8'h7F);
    if (pm == 2'd1) return ($countones(dd) % 2) == 1;
    if (pm == 2'd2) return ($countones(dd) % 2) == 0;
    return 1'b1;
  endfunction

  task automatic drive(input logic v, input int n);
    rx_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic ws,
                            input logic [1:0] pm,
                            input logic pbit,
                            input logic stop);
    parityMode = pm;
    wordSize   = ws;
    drive(1'b0, BIT);
    parityMode = 2'($urandom);
    wordSize   = 1'($urandom);
    for (int i = 0; i < (ws ? 8 : 7); i++) drive(d[i], BIT);
    if (pm != 2'd0) drive(pbit, BIT);
    drive(stop, BIT);
  endtask

  task automatic expect_frame(input string tag,
                              input logic [9:0] exp,
                              input logic full);
    drive(1'b1, 2 * BIT);
    check({tag, "_nwr"}, wq.size(), full ? 0 : 1);
    if (wq.size() > 0 && !full) check({tag, "_data"}, wq[0], exp);
    check({tag, "_ovr"}, ov_cnt, full ? 1 : 0);
    check({tag, "_busy"}, rx_busy, 0);
    wq.delete();
    ov_cnt = 0;
  endtask

  initial begin
    logic [7:0] d;
    logic       ws;
    logic [1:0] pm;
    logic       pb;
    logic       st;
    logic       fl;

    reset       = 1'b1;
    rx_in       = 1'b1;
    parityMode  = 2'd0;
    wordSize    = 1'b1;
    bus.rx_full = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_write", bus.rx_write, 0);
    check("rst_ovr", bus.rx_overrun, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_data", bus.rx_data, 0);

    send_frame(8'hA5, 1'b1, 2'd0, 1'b0, 1'b1);
    expect_frame("8n1_a5", 10'h0A5, 1'b0);

    send_frame(8'h53, 1'b0, 2'd1, 1'b0, 1'b1);
    expect_frame("7e1_ok", 10'h053, 1'b0);
    send_frame(8'h53, 1'b0, 2'd1, 1'b1, 1'b1);
    expect_frame("7e1_bad", 10'h153, 1'b0);

    drive(1'b0, 5 * 4);
    check("fs_busy", rx_busy, 1);
    drive(1'b1, 3 * BIT);
    check("fs_nwr", wq.size(), 0);
    check("fs_idle", rx_busy, 0);
    check("fs_hold", bus.rx_data, 10'h153);

    send_frame(8'h3C, 1'b1, 2'd0, 1'b0, 1'b0);
    drive(1'b0, 3 * BIT);
    check("brk_busy", rx_busy, 1);
    check("brk_nwr", wq.size(), 1);
    expect_frame("brk", 10'h23C, 1'b0);

    bus.rx_full = 1'b1;
    send_frame(8'h7E, 1'b1, 2'd0, 1'b0, 1'b1);
    expect_frame("full_7e", 10'h07E, 1'b1);
    bus.rx_full = 1'b0;
    send_frame(8'h81, 1'b1, 2'd0, 1'b0, 1'b1);
    expect_frame("after_full", 10'h081, 1'b0);

    parityMode = 2'd0;
    wordSize   = 1'b1;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(1'b1, BIT);
    drive(1'b0, BIT / 2);
    reset = 1'b1;
    drive(1'b0, 1);
    reset = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", rx_busy, 0);
    drive(1'b1, 2 * BIT);
    check("mid_rst_nwr", wq.size(), 0);
    send_frame(8'h01, 1'b1, 2'd2, 1'b0, 1'b1);
    expect_frame("8o1_01", 10'h001, 1'b0);

    for (int n = 0; n < 20; n++) begin
      d  = 8'($urandom);
      ws = 1'($urandom);
      pm = 2'($urandom);
      pb = good_par(d, ws, pm) ^ ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 7) != 0);
      fl = ($urandom_range(0, 7) == 0);
      bus.rx_full = fl;
      send_frame(d, ws, pm, pb, st);
      expect_frame($sformatf("rnd%0d", n), model(d, ws, pm, pb, st), fl);
      bus.rx_full = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
